// File: rtl/qenc_pkg.sv
// Shared types and phase helpers for the quadrature encoder generator.
// The phase table lists {A,B} in positive order, so A leads B when counting up.
package qenc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] PHASE_SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Moves one entry along PHASE_SEQ: forward for dir=1, backward for dir=0.
    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
        logic [1:0] idx;
        logic [1:0] nidx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (PHASE_SEQ[i] == phase) begin
                idx = 2'(i);
            end
        end
        nidx = dir ? (idx + 2'd1) : (idx - 2'd1);
        return PHASE_SEQ[nidx];
    endfunction

endpackage

// File: rtl/qenc_step_timer.sv
// Step-rate timer: counts 0..period_i-1 while enabled and pulses tick_o on the terminal count.
// load_i clears the count; a disabled timer holds its count so a pause resumes mid-interval.
module qenc_step_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [31:0] period_i,
    output logic        tick_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // period_i is never 0 here; the owner clamps it to at least 1.
    assign tick_o = en_i & (cnt_q == (period_i - 32'd1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = 32'd0;
        end else if (en_i) begin
            cnt_d = tick_o ? 32'd0 : (cnt_q + 32'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quadrature_encoder_gen.sv
// Quadrature A/B/Z generator driven by signed step commands; tracks emitted position as integer.fraction.
// Optional contact bounce after each edge when built with QENC_GEN_GLITCH_EN (adds i_glitch_en).
module quadrature_encoder_gen
    import qenc_pkg::*;
#(
    parameter int POSITION_SIZE = 32,
    parameter int CMD_WIDTH     = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       enable,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [CMD_WIDTH-1:0]       i_cmd_steps,
    input  logic [31:0]                step_period,
    input  logic [POSITION_SIZE/2:0]   steps_in_circle,
    input  logic                       i_pos_load,
    input  logic [POSITION_SIZE-1:0]   zero_position,
`ifdef QENC_GEN_GLITCH_EN
    input  logic                       i_glitch_en,
`endif
    output logic                       o_a,
    output logic                       o_b,
    output logic                       o_z,
    output logic                       busy,
    output logic                       direction,
    output logic                       o_done,
    output logic [POSITION_SIZE-1:0]   position
);

    localparam int H = POSITION_SIZE / 2;
    localparam logic [H-1:0]         ONE_H   = 1;
    localparam logic [H:0]           ONE_H1  = 1;
    localparam logic [H:0]           SIC_MAX = {1'b1, {H{1'b0}}};
    localparam logic [CMD_WIDTH-1:0] ONE_C   = 1;

    state_e                 state_q;
    logic [CMD_WIDTH-1:0]   remaining_q;
    logic                   cmd_dir_q;
    logic [31:0]            period_q;
    logic [1:0]             phase_q;
    logic                   z_q;
    logic                   dir_q;
    logic                   done_q;
    logic [H-1:0]           frac_q;
    logic [H-1:0]           int_q;

    logic                   accept;
    logic                   run_en;
    logic                   step_tick;
    logic [CMD_WIDTH-1:0]   cmd_abs;
    logic                   cmd_zero;
    logic [31:0]            period_eff;
    logic [H:0]             sic_eff;
    logic [H:0]             sic_m1;
    logic [H-1:0]           frac_d;
    logic [H-1:0]           int_d;
    logic [1:0]             phase_d;
    logic [1:0]             ab;

    assign o_cmd_ready = enable & (state_q == ST_IDLE);
    assign accept      = o_cmd_ready & i_cmd_valid;
    assign run_en      = enable & (state_q == ST_RUN);

    // Two's-complement magnitude: the most-negative command maps to 2^(CMD_WIDTH-1).
    assign cmd_abs    = i_cmd_steps[CMD_WIDTH-1] ? (-i_cmd_steps) : i_cmd_steps;
    assign cmd_zero   = (i_cmd_steps == '0);
    assign period_eff = (step_period == 32'd0) ? 32'd1 : step_period;

    assign sic_eff = (steps_in_circle == '0) ? SIC_MAX : steps_in_circle;
    assign sic_m1  = sic_eff - ONE_H1;
    assign phase_d = next_phase(phase_q, cmd_dir_q);

    always_comb begin
        frac_d = frac_q;
        int_d  = int_q;
        if (cmd_dir_q) begin
            if ({1'b0, frac_q} == sic_m1) begin
                frac_d = '0;
                int_d  = int_q + ONE_H;
            end else begin
                frac_d = frac_q + ONE_H;
            end
        end else begin
            if (frac_q == '0) begin
                frac_d = sic_m1[H-1:0];
                int_d  = int_q - ONE_H;
            end else begin
                frac_d = frac_q - ONE_H;
            end
        end
    end

    qenc_step_timer u_timer (
        .clk_i    (i_clk),
        .rst_i    (i_reset),
        .load_i   (accept),
        .en_i     (run_en),
        .period_i (period_q),
        .tick_o   (step_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            cmd_dir_q   <= 1'b0;
            period_q    <= 32'd1;
            phase_q     <= 2'b00;
            z_q         <= 1'b0;
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
            frac_q      <= '0;
            int_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (enable) begin
                case (state_q)
                    ST_IDLE: begin
                        // Load first so a same-cycle command starts from the loaded position.
                        if (i_pos_load) begin
                            frac_q <= zero_position[H-1:0];
                            int_q  <= zero_position[POSITION_SIZE-1:H];
                            z_q    <= 1'b0;
                        end
                        if (i_cmd_valid) begin
                            if (cmd_zero) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q     <= ST_RUN;
                                remaining_q <= cmd_abs;
                                cmd_dir_q   <= ~i_cmd_steps[CMD_WIDTH-1];
                                period_q    <= period_eff;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (step_tick) begin
                            phase_q     <= phase_d;
                            frac_q      <= frac_d;
                            int_q       <= int_d;
                            z_q         <= (frac_d == '0);
                            dir_q       <= cmd_dir_q;
                            remaining_q <= remaining_q - ONE_C;
                            if (remaining_q == ONE_C) begin
                                state_q <= ST_IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef QENC_GEN_GLITCH_EN
    logic [1:0] ab_q;
    logic [1:0] gl_mask_q;
    logic [1:0] gl_cnt_q;

    // Bounce sequence: edge, hold 1 clk, old level for 1 clk, then settle on the new level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ab_q      <= 2'b00;
            gl_mask_q <= 2'b00;
            gl_cnt_q  <= 2'd0;
        end else if (enable) begin
            if (step_tick) begin
                ab_q      <= phase_d;
                gl_mask_q <= phase_q ^ phase_d;
                gl_cnt_q  <= (i_glitch_en && (period_q >= 32'd4)) ? 2'd1 : 2'd0;
            end else begin
                case (gl_cnt_q)
                    2'd1: gl_cnt_q <= 2'd2;
                    2'd2: begin
                        ab_q     <= phase_q ^ gl_mask_q;
                        gl_cnt_q <= 2'd3;
                    end
                    2'd3: begin
                        ab_q     <= phase_q;
                        gl_cnt_q <= 2'd0;
                    end
                    default: gl_cnt_q <= 2'd0;
                endcase
            end
        end
    end

    assign ab = ab_q;
`else
    assign ab = phase_q;
`endif

    assign o_a       = ab[1];
    assign o_b       = ab[0];
    assign o_z       = z_q;
    assign busy      = (state_q == ST_RUN);
    assign direction = dir_q;
    assign o_done    = done_q;
    assign position  = {int_q, frac_q};

endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// Bench for quadrature_encoder_gen: directed scenarios plus randomized commands against a position/phase model.
module tb_quadrature_encoder_gen;

    localparam int PS = 32;
    localparam int CW = 32;
    localparam int H  = 16;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          enable = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          i_pos_load = 1'b0;
    logic [CW-1:0] i_cmd_steps = '0;
    logic [31:0]   step_period = 32'd4;
    logic [H:0]    steps_in_circle = 17'd100;
    logic [PS-1:0] zero_position = '0;
    logic          o_cmd_ready, o_a, o_b, o_z, busy, direction, o_done;
    logic [PS-1:0] position;
`ifdef QENC_GEN_GLITCH_EN
    logic          i_glitch_en = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Model: net step count since reset gives phase; position kept as integer/fraction pair.
    int     ph_m = 0;
    longint frac_m = 0;
    longint int_m = 0;
    logic   dir_m = 1'b0;

    always #5 i_clk = ~i_clk;

    quadrature_encoder_gen #(.POSITION_SIZE(PS), .CMD_WIDTH(CW)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .enable          (enable),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_steps     (i_cmd_steps),
        .step_period     (step_period),
        .steps_in_circle (steps_in_circle),
        .i_pos_load      (i_pos_load),
        .zero_position   (zero_position),
`ifdef QENC_GEN_GLITCH_EN
        .i_glitch_en     (i_glitch_en),
`endif
        .o_a             (o_a),
        .o_b             (o_b),
        .o_z             (o_z),
        .busy            (busy),
        .direction       (direction),
        .o_done          (o_done),
        .position        (position)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [1:0] ab_of(input int idx);
        case (((idx % 4) + 4) % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic longint fmod(input longint a, input longint m);
        longint r;
        r = a % m;
        if (r < 0) r += m;
        return r;
    endfunction

    function automatic logic [31:0] exp_pos();
        logic [63:0] iv;
        logic [63:0] fv;
        iv = 64'(int_m);
        fv = 64'(frac_m);
        return {iv[15:0], fv[15:0]};
    endfunction

    task automatic model_reset();
        ph_m = 0; frac_m = 0; int_m = 0; dir_m = 1'b0;
    endtask

    // mode: 0 plain, 1 poke valid/load while busy, 2 pause 10 clks after 1st edge, 3 reset after 2nd edge
    task automatic run_cmd(input int cmd, input int period, input int sicv,
                           input bit do_load, input logic [31:0] zpos, input int mode);
        int per, n, s, cyc, seen, budget, paused;
        longint m, lin0, lin;
        logic [1:0] prev;
        per = (period < 1) ? 1 : period;
        n   = (cmd < 0) ? -cmd : cmd;
        s   = (cmd < 0) ? -1 : 1;
        m   = (sicv == 0) ? 65536 : sicv;
        steps_in_circle = 17'(sicv);
        step_period     = 32'(period);
        enable = 1'b1;
        chk("ready_idle", {63'd0, o_cmd_ready}, 64'd1);
        i_cmd_valid = 1'b1; i_cmd_steps = 32'(cmd);
        i_pos_load = do_load; zero_position = zpos;
        tick();
        i_cmd_valid = 1'b0; i_pos_load = 1'b0;
        if (do_load) begin
            frac_m = longint'(zpos[15:0]);
            int_m  = longint'($signed(zpos[31:16]));
        end
        lin0 = int_m * m + frac_m;
        if (n == 0) begin
            chk("done_zero_cmd", {63'd0, o_done}, 64'd1);
            chk("busy_zero_cmd", {63'd0, busy}, 64'd0);
            chk("ab_zero_cmd", {62'd0, o_a, o_b}, {62'd0, ab_of(ph_m)});
            chk("pos_zero_cmd", {32'd0, position}, {32'd0, exp_pos()});
            tick();
            chk("done_zero_drop", {63'd0, o_done}, 64'd0);
            return;
        end
        chk("busy_start", {63'd0, busy}, 64'd1);
        prev = {o_a, o_b}; cyc = 0; seen = 0; budget = 0; paused = 0;
        while (seen < n && budget < 2000) begin
            if (mode == 1 && cyc < per - 1) begin
                i_cmd_valid = 1'b1; i_cmd_steps = 32'd5;
                i_pos_load = 1'b1; zero_position = 32'h1234_0005;
            end else begin
                i_cmd_valid = 1'b0; i_pos_load = 1'b0;
            end
            if (mode == 2 && seen == 1 && paused < 10) begin
                enable = 1'b0; paused++;
            end else begin
                enable = 1'b1;
            end
            tick();
            budget++;
            if (enable) cyc++;
            if (mode == 1 && i_cmd_valid) chk("ready_while_busy", {63'd0, o_cmd_ready}, 64'd0);
            if ({o_a, o_b} !== prev) begin
                seen++;
                ph_m += s;
                dir_m = (s > 0);
                lin = lin0 + longint'(seen) * longint'(s);
                frac_m = fmod(lin, m);
                int_m  = (lin - frac_m) / m;
                chk("edge_time", 64'(cyc), 64'(seen * per));
                chk("ab_phase", {62'd0, o_a, o_b}, {62'd0, ab_of(ph_m)});
                chk("direction", {63'd0, direction}, {63'd0, dir_m});
                chk("z", {63'd0, o_z}, {63'd0, (frac_m == 0)});
                chk("done", {63'd0, o_done}, {63'd0, (seen == n)});
                chk("busy", {63'd0, busy}, {63'd0, (seen != n)});
                chk("position", {32'd0, position}, {32'd0, exp_pos()});
                prev = {o_a, o_b};
                if (mode == 3 && seen == 2) begin
                    i_reset = 1'b1;
                    tick();
                    i_reset = 1'b0;
                    model_reset();
                    chk("rst_ab", {62'd0, o_a, o_b}, 64'd0);
                    chk("rst_z_dir_done", {61'd0, o_z, direction, o_done}, 64'd0);
                    chk("rst_busy", {63'd0, busy}, 64'd0);
                    chk("rst_position", {32'd0, position}, 64'd0);
                    return;
                end
            end else if (!enable) begin
                chk("pause_ab", {62'd0, o_a, o_b}, {62'd0, ab_of(ph_m)});
                chk("pause_pos", {32'd0, position}, {32'd0, exp_pos()});
            end
        end
        i_cmd_valid = 1'b0; i_pos_load = 1'b0; enable = 1'b1;
        chk("all_edges_seen", 64'(seen), 64'(n));
        tick();
        chk("done_pulse_end", {63'd0, o_done}, 64'd0);
        chk("no_extra_edge", {62'd0, o_a, o_b}, {62'd0, ab_of(ph_m)});
        chk("ready_after", {63'd0, o_cmd_ready}, 64'd1);
    endtask

    initial begin
        int last_sic;
        int cmd, per, sicv, mode;
        bit ld;
        logic [31:0] zp;
        int sics [5] = '{1, 4, 7, 100, 0};

        // Reset state
        repeat (3) tick();
        chk("reset_ab", {62'd0, o_a, o_b}, 64'd0);
        chk("reset_z", {63'd0, o_z}, 64'd0);
        chk("reset_busy_dir_done", {61'd0, busy, direction, o_done}, 64'd0);
        chk("reset_position", {32'd0, position}, 64'd0);
        chk("ready_disabled", {63'd0, o_cmd_ready}, 64'd0);
        i_reset = 1'b0;
        tick();
        enable = 1'b1;
        #1;
        chk("ready_enabled", {63'd0, o_cmd_ready}, 64'd1);

        // +8 at period 4
        run_cmd(8, 4, 100, 1'b0, 32'h0, 0);
        chk("pos_plus8", {32'd0, position}, 64'h0000_0008);
        chk("dir_plus8", {63'd0, direction}, 64'd1);

        // -3 from 0 with 100 steps per turn
        run_cmd(-3, 2, 100, 1'b1, 32'h0, 0);
        chk("pos_minus3", {32'd0, position}, 64'hFFFF_0061);
        chk("dir_minus3", {63'd0, direction}, 64'd0);

        // 4 steps per turn, +9: Z at fraction 0
        run_cmd(9, 2, 4, 1'b1, 32'h0, 0);
        chk("pos_plus9_sic4", {32'd0, position}, 64'h0002_0001);

        // Zero command
        run_cmd(0, 3, 4, 1'b0, 32'h0, 0);

        // Commands and loads while busy are ignored
        run_cmd(3, 4, 4, 1'b0, 32'h0, 1);
        chk("pos_after_busy_poke", {32'd0, position}, 64'h0003_0000);
        chk("z_at_turn", {63'd0, o_z}, 64'd1);

        // Standalone load in IDLE clears Z, keeps phase
        i_pos_load = 1'b1; zero_position = 32'h0005_0003;
        tick();
        i_pos_load = 1'b0;
        frac_m = 3; int_m = 5;
        chk("load_position", {32'd0, position}, 64'h0005_0003);
        chk("load_z", {63'd0, o_z}, 64'd0);
        chk("load_ab", {62'd0, o_a, o_b}, {62'd0, ab_of(ph_m)});

        // Pause mid-run
        run_cmd(4, 3, 4, 1'b0, 32'h0, 2);

        // Reset mid-run
        run_cmd(20, 3, 100, 1'b1, 32'h0, 3);
        last_sic = 100;

        // Randomized commands
        for (int it = 0; it < 10; it++) begin
            cmd  = int'($urandom_range(0, 24)) - 12;
            per  = int'($urandom_range(0, 5));
            sicv = sics[$urandom_range(0, 4)];
            ld   = (sicv != last_sic) ? 1'b1 : 1'($urandom_range(0, 1));
            zp[31:16] = 16'($urandom);
            zp[15:0]  = 16'($urandom_range(0, (sicv == 0) ? 65535 : sicv - 1));
            mode = ((cmd > 1) || (cmd < -1)) ? int'($urandom_range(0, 2)) : 0;
            run_cmd(cmd, per, sicv, ld, zp, mode);
            last_sic = sicv;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
